// File: rtl/axi4lite_reg_bank.sv
// AXI4-Lite subordinate register bank with byte strobes, read-only status slots,
// per-register write pulses and SLVERR for unmapped or read-only writes.
`timescale 1ns/1ps
module axi4lite_reg_bank #(
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  NUM_REGS           = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e            wr_state_q, wr_state_d;
    rd_state_e            rd_state_q, rd_state_d;
    logic [DW-1:0]        regs_q [NUM_REGS];
    logic [IDX_W-1:0]     awidx_q;
    logic [DW-1:0]        wdata_q;
    logic [SW-1:0]        wstrb_q;
    logic [1:0]           bresp_q;
    logic [DW-1:0]        rdata_q;
    logic [1:0]           rresp_q;
    logic [NUM_REGS-1:0]  wr_pulse_q;

    logic                 aw_hs, w_hs, ar_hs, commit, wr_ok, rd_hit;
    logic [IDX_W-1:0]     widx, ridx;
    logic [DW-1:0]        cdata, rd_val;
    logic [SW-1:0]        cstrb;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_W);
    assign S_AXI_WREADY  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_HAVE_AW);
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rd_state_q == RD_IDLE);
    assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Whichever half arrived first comes from the latch, the other from the live bus.
    assign widx  = (wr_state_q == WR_HAVE_AW) ? awidx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign cdata = (wr_state_q == WR_HAVE_W) ? wdata_q : S_AXI_WDATA;
    assign cstrb = (wr_state_q == WR_HAVE_W) ? wstrb_q : S_AXI_WSTRB;
    assign ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    always_comb begin
        wr_state_d = wr_state_q;
        commit     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end else if (aw_hs) begin
                    wr_state_d = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                commit     = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_HAVE_W: if (aw_hs) begin
                commit     = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RD_IDLE: if (S_AXI_ARVALID) rd_state_d = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Out-of-range indices match no register, so they fall out as errors naturally.
    always_comb begin
        wr_ok  = 1'b0;
        rd_hit = 1'b0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == IDX_W'(i) && !RO_MASK[i]) wr_ok = 1'b1;
            if (ridx == IDX_W'(i)) begin
                rd_hit = 1'b1;
                rd_val = RO_MASK[i] ? status_in[i*DW +: DW] : regs_q[i];
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_pulse_q <= '0;
            if (aw_hs) awidx_q <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_ok && widx == IDX_W'(i)) begin
                        wr_pulse_q[i] <= 1'b1;
                        for (int k = 0; k < SW; k++)
                            if (cstrb[k]) regs_q[i][k*8 +: 8] <= cdata[k*8 +: 8];
                    end
                end
            end
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_out[g*DW +: DW] = RO_MASK[g] ? '0 : regs_q[g];
    end

endmodule

// File: tb/tb_axi4lite_reg_bank.sv
// Directed self-checking bench for axi4lite_reg_bank (8 regs, register 7 read-only).
`timescale 1ns/1ps
module tb_axi4lite_reg_bank;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   awAddr, arAddr;
    logic         awValid, wValid, bReady, arValid, rReady;
    logic         awReady, wReady, bValid, arReady, rValid;
    logic [31:0]  wData, rData;
    logic [3:0]   wStrb;
    logic [1:0]   bResp, rResp;
    logic [255:0] ctrlOut, statusIn;
    logic [7:0]   wrPulse;
    int           compared = 0;
    int           mismatched = 0;

    always #5 clock = ~clock;

    axi4lite_reg_bank #(
        .C_S_AXI_ADDR_WIDTH(6), .C_S_AXI_DATA_WIDTH(32), .NUM_REGS(8), .RO_MASK(8'h80)
    ) dut (
        .S_AXI_ACLK(clock), .S_AXI_ARESET(reset),
        .S_AXI_AWADDR(awAddr), .S_AXI_AWVALID(awValid), .S_AXI_AWREADY(awReady),
        .S_AXI_WDATA(wData), .S_AXI_WSTRB(wStrb), .S_AXI_WVALID(wValid), .S_AXI_WREADY(wReady),
        .S_AXI_BRESP(bResp), .S_AXI_BVALID(bValid), .S_AXI_BREADY(bReady),
        .S_AXI_ARADDR(arAddr), .S_AXI_ARVALID(arValid), .S_AXI_ARREADY(arReady),
        .S_AXI_RDATA(rData), .S_AXI_RRESP(rResp), .S_AXI_RVALID(rValid), .S_AXI_RREADY(rReady),
        .ctrl_out(ctrlOut), .status_in(statusIn), .wr_pulse(wrPulse)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic writeBoth(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awAddr = addr; wData = data; wStrb = strb;
        awValid = 1'b1; wValid = 1'b1; bReady = 1'b1;
        tick();
        awValid = 1'b0; wValid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        compared++; if (awReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_awready: got %b want 1", awReady); end
        compared++; if (wReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_wready: got %b want 1", wReady); end
        compared++; if (arReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_arready: got %b want 1", arReady); end
        compared++; if (bValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_bvalid: got %b want 0", bValid); end
        compared++; if (rValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rvalid: got %b want 0", rValid); end
        compared++; if (ctrlOut !== 256'd0) begin mismatched++; $display("[TB] FAIL reset_ctrl: got %h want 0", ctrlOut); end
        compared++; if (wrPulse !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_pulse: got %h want 00", wrPulse); end
        compared++; if (rData !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", rData); end
        reset = 1'b0;
    endtask

    task automatic test_write_together();
        awAddr = 6'h04; wData = 32'hDEADBEEF; wStrb = 4'hF;
        awValid = 1'b1; wValid = 1'b1; bReady = 1'b1;
        tick();
        compared++; if (bValid !== 1'b1) begin mismatched++; $display("[TB] FAIL wt_bvalid: got %b want 1", bValid); end
        compared++; if (bResp !== 2'b00) begin mismatched++; $display("[TB] FAIL wt_bresp: got %b want 00", bResp); end
        compared++; if (ctrlOut[1*32 +: 32] !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL wt_slot1: got %h want deadbeef", ctrlOut[1*32 +: 32]); end
        compared++; if (wrPulse !== 8'b0000_0010) begin mismatched++; $display("[TB] FAIL wt_pulse: got %b want 00000010", wrPulse); end
        compared++; if (awReady !== 1'b0) begin mismatched++; $display("[TB] FAIL wt_awready_resp: got %b want 0", awReady); end
        awValid = 1'b0; wValid = 1'b0;
        tick();
        compared++; if (bValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wt_bvalid_done: got %b want 0", bValid); end
        compared++; if (wrPulse !== 8'h00) begin mismatched++; $display("[TB] FAIL wt_pulse_once: got %b want 0", wrPulse); end
        compared++; if (awReady !== 1'b1 || wReady !== 1'b1) begin mismatched++; $display("[TB] FAIL wt_readies_back: got %b%b want 11", awReady, wReady); end
        arAddr = 6'h04; arValid = 1'b1; rReady = 1'b1;
        tick();
        compared++; if (rValid !== 1'b1) begin mismatched++; $display("[TB] FAIL wt_rvalid: got %b want 1", rValid); end
        compared++; if (rData !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL wt_rdata: got %h want deadbeef", rData); end
        compared++; if (rResp !== 2'b00) begin mismatched++; $display("[TB] FAIL wt_rresp: got %b want 00", rResp); end
        arValid = 1'b0;
        tick();
        compared++; if (rValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wt_rvalid_done: got %b want 0", rValid); end
    endtask

    task automatic test_aw_first();
        writeBoth(6'h08, 32'hAAAAAAAA, 4'hF);
        awAddr = 6'h08; awValid = 1'b1;
        tick();
        compared++; if (awReady !== 1'b0 || wReady !== 1'b1) begin mismatched++; $display("[TB] FAIL awf_readies: got %b%b want 01", awReady, wReady); end
        awValid = 1'b0; awAddr = 6'h3C;
        repeat (2) begin
            tick();
            compared++; if (awReady !== 1'b0) begin mismatched++; $display("[TB] FAIL awf_awready_wait: got %b want 0", awReady); end
        end
        wData = 32'h11223344; wStrb = 4'b0101; wValid = 1'b1; bReady = 1'b0;
        tick();
        compared++; if (bValid !== 1'b1) begin mismatched++; $display("[TB] FAIL awf_bvalid: got %b want 1", bValid); end
        compared++; if (ctrlOut[2*32 +: 32] !== 32'hAA22AA44) begin mismatched++; $display("[TB] FAIL awf_slot2: got %h want aa22aa44", ctrlOut[2*32 +: 32]); end
        compared++; if (wrPulse !== 8'b0000_0100) begin mismatched++; $display("[TB] FAIL awf_pulse: got %b want 00000100", wrPulse); end
        wValid = 1'b0;
        repeat (4) begin
            tick();
            compared++; if (bValid !== 1'b1 || bResp !== 2'b00) begin mismatched++; $display("[TB] FAIL awf_bhold: got v=%b r=%b want v=1 r=00", bValid, bResp); end
            compared++; if (awReady !== 1'b0 || wReady !== 1'b0) begin mismatched++; $display("[TB] FAIL awf_readies_resp: got %b%b want 00", awReady, wReady); end
        end
        bReady = 1'b1;
        tick();
        compared++; if (bValid !== 1'b0 || awReady !== 1'b1 || wReady !== 1'b1) begin mismatched++; $display("[TB] FAIL awf_release: got b=%b aw=%b w=%b want 0 1 1", bValid, awReady, wReady); end
    endtask

    task automatic test_read_only();
        awAddr = 6'h1C; wData = 32'h12345678; wStrb = 4'hF;
        awValid = 1'b1; wValid = 1'b1; bReady = 1'b1;
        tick();
        compared++; if (bValid !== 1'b1 || bResp !== 2'b10) begin mismatched++; $display("[TB] FAIL ro_bresp: got v=%b r=%b want v=1 r=10", bValid, bResp); end
        compared++; if (wrPulse !== 8'h00) begin mismatched++; $display("[TB] FAIL ro_pulse: got %b want 0", wrPulse); end
        compared++; if (ctrlOut[7*32 +: 32] !== 32'h0) begin mismatched++; $display("[TB] FAIL ro_slot7: got %h want 0", ctrlOut[7*32 +: 32]); end
        awValid = 1'b0; wValid = 1'b0;
        tick();
        arAddr = 6'h1C; arValid = 1'b1; rReady = 1'b1;
        tick();
        compared++; if (rData !== 32'hCAFE0001 || rResp !== 2'b00) begin mismatched++; $display("[TB] FAIL ro_read: got %h/%b want cafe0001/00", rData, rResp); end
        arValid = 1'b0;
        tick();
        arAddr = 6'h3C; arValid = 1'b1;
        tick();
        compared++; if (rValid !== 1'b1 || rData !== 32'h0 || rResp !== 2'b10) begin mismatched++; $display("[TB] FAIL oob_read: got v=%b %h/%b want 1 0/10", rValid, rData, rResp); end
        arValid = 1'b0;
        tick();
        awAddr = 6'h3C; awValid = 1'b1; wValid = 1'b1;
        tick();
        compared++; if (bResp !== 2'b10 || wrPulse !== 8'h00) begin mismatched++; $display("[TB] FAIL oob_write: got r=%b p=%b want 10 0", bResp, wrPulse); end
        awValid = 1'b0; wValid = 1'b0;
        tick();
    endtask

    task automatic test_read_during_write();
        writeBoth(6'h0C, 32'd5, 4'hF);
        awAddr = 6'h0C; wData = 32'd9; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1; bReady = 1'b1;
        arAddr = 6'h0C; arValid = 1'b1; rReady = 1'b0;
        tick();
        compared++; if (rValid !== 1'b1 || rData !== 32'd5) begin mismatched++; $display("[TB] FAIL rdw_old: got v=%b %h want 1 5", rValid, rData); end
        compared++; if (ctrlOut[3*32 +: 32] !== 32'd9) begin mismatched++; $display("[TB] FAIL rdw_slot3: got %h want 9", ctrlOut[3*32 +: 32]); end
        awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
        repeat (2) begin
            tick();
            compared++; if (rValid !== 1'b1 || rData !== 32'd5 || arReady !== 1'b0) begin mismatched++; $display("[TB] FAIL rdw_hold: got v=%b %h ar=%b want 1 5 0", rValid, rData, arReady); end
        end
        rReady = 1'b1;
        tick();
        compared++; if (rValid !== 1'b0 || arReady !== 1'b1) begin mismatched++; $display("[TB] FAIL rdw_release: got v=%b ar=%b want 0 1", rValid, arReady); end
        arValid = 1'b1;
        tick();
        compared++; if (rData !== 32'd9) begin mismatched++; $display("[TB] FAIL rdw_new: got %h want 9", rData); end
        arValid = 1'b0;
        tick();
    endtask

    task automatic test_w_first();
        wData = 32'h12345678; wStrb = 4'b0011; wValid = 1'b1; bReady = 1'b1;
        tick();
        compared++; if (wReady !== 1'b0 || awReady !== 1'b1 || bValid !== 1'b0) begin mismatched++; $display("[TB] FAIL wf_wait: got w=%b aw=%b b=%b want 0 1 0", wReady, awReady, bValid); end
        wValid = 1'b0; wData = 32'hFFFFFFFF; wStrb = 4'hF;
        tick();
        awAddr = 6'h14; awValid = 1'b1;
        tick();
        compared++; if (ctrlOut[5*32 +: 32] !== 32'h00005678 || wrPulse !== 8'h20) begin mismatched++; $display("[TB] FAIL wf_commit: got %h p=%h want 00005678 20", ctrlOut[5*32 +: 32], wrPulse); end
        awValid = 1'b0;
        tick();
        writeBoth(6'h14, 32'hFFFFFFFF, 4'b0000);
        awAddr = 6'h14; wStrb = 4'b0000; awValid = 1'b1; wValid = 1'b1;
        tick();
        compared++; if (bResp !== 2'b00 || wrPulse !== 8'h20 || ctrlOut[5*32 +: 32] !== 32'h00005678) begin mismatched++; $display("[TB] FAIL zero_strb: got r=%b p=%h %h want 00 20 00005678", bResp, wrPulse, ctrlOut[5*32 +: 32]); end
        awValid = 1'b0; wValid = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        awAddr = 6'h00; wData = 32'h1; wStrb = 4'hF; awValid = 1'b1; wValid = 1'b1; bReady = 1'b0;
        arAddr = 6'h00; arValid = 1'b1; rReady = 1'b0;
        tick();
        awValid = 1'b0; wValid = 1'b0; arValid = 1'b0;
        compared++; if (bValid !== 1'b1 || rValid !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_pending: got b=%b r=%b want 1 1", bValid, rValid); end
        reset = 1'b1;
        tick();
        compared++; if (bValid !== 1'b0 || rValid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_drop: got b=%b r=%b want 0 0", bValid, rValid); end
        compared++; if (ctrlOut !== 256'd0) begin mismatched++; $display("[TB] FAIL abort_regs: got %h want 0", ctrlOut); end
        reset = 1'b0; bReady = 1'b1; rReady = 1'b1;
        repeat (3) begin
            tick();
            compared++; if (bValid !== 1'b0 || rValid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_silent: got b=%b r=%b want 0 0", bValid, rValid); end
        end
    endtask

    initial begin
        reset = 1'b1; awAddr = '0; arAddr = '0; wData = '0; wStrb = '0;
        awValid = 1'b0; wValid = 1'b0; bReady = 1'b0; arValid = 1'b0; rReady = 1'b0;
        statusIn = '0;
        statusIn[7*32 +: 32] = 32'hCAFE0001;
        statusIn[1*32 +: 32] = 32'h55555555;
        test_reset();
        test_write_together();
        test_aw_first();
        test_read_only();
        test_read_during_write();
        test_w_first();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
